// File: rtl/masked_sram_pkg.sv
// rtl/masked_sram_pkg.sv - shared types and constants for the masked SRAM model
//
// Purpose: FSM state encoding and LFSR constants used by masked_sram_ext and
// masked_sram_lfsr.
// Ports: none (package).
package masked_sram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } sram_state_e;

  localparam logic [31:0] LFSR_POLY = 32'h80200003;
  localparam logic [31:0] LFSR_SEED = 32'h00000001;

endpackage

// File: rtl/masked_sram_lfsr.sv
// rtl/masked_sram_lfsr.sv - 32-bit Galois LFSR used as garbage read-data source
//
// Purpose: right-shifting Galois LFSR; holds when en_i=0, returns to seed on reset.
// Ports:
//   clk_i   - clock, rising edge
//   rst_i   - synchronous active-high reset (state <= seed)
//   en_i    - advance one step per cycle when high
//   state_o - current LFSR state
module masked_sram_lfsr
  import masked_sram_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic [31:0] state_o
);

  logic [31:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (en_i) begin
      state_d = state_q[0] ? ((state_q >> 1) ^ LFSR_POLY) : (state_q >> 1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= LFSR_SEED;
    else       state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/masked_sram_ext.sv
// rtl/masked_sram_ext.sv - parametrised single-port byte-masked SRAM with init sweep
//
// Purpose: behavioural single-port array. After reset it sweeps INIT_VAL into
// every word (RW0_ready low), then serves one masked write or read per cycle.
// Optional macro MASKED_SRAM_GARBAGE_EN drives LFSR garbage on RW0_rdata
// whenever RW0_rvalid is low in RUN.
// Ports:
//   RW0_clk    - clock, rising edge
//   RW0_reset  - synchronous active-high reset
//   RW0_addr   - word address
//   RW0_en     - request enable
//   RW0_wmode  - 1 = write, 0 = read
//   RW0_wmask  - per-lane write enable, GRAN bits per lane
//   RW0_wdata  - write data
//   RW0_rdata  - read data
//   RW0_rvalid - one-cycle strobe marking a read response
//   RW0_ready  - high once the init sweep has finished
module masked_sram_ext
  import masked_sram_pkg::*;
#(
  parameter int                 DATA_W   = 64,
  parameter int                 DEPTH    = 512,
  parameter int                 ADDR_W   = 9,
  parameter int                 GRAN     = 8,
  parameter int                 OUT_REG  = 0,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  logic                     RW0_clk,
  input  logic                     RW0_reset,
  input  logic [ADDR_W-1:0]        RW0_addr,
  input  logic                     RW0_en,
  input  logic                     RW0_wmode,
  input  logic [DATA_W/GRAN-1:0]   RW0_wmask,
  input  logic [DATA_W-1:0]        RW0_wdata,
  output logic [DATA_W-1:0]        RW0_rdata,
  output logic                     RW0_rvalid,
  output logic                     RW0_ready
);

  localparam int                MW        = DATA_W / GRAN;
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  sram_state_e       state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              ready_q;

  logic [DATA_W-1:0] ram [DEPTH];

  logic req_ok, rd_req, addr_ok;
  assign req_ok  = ready_q & RW0_en;
  assign rd_req  = req_ok & ~RW0_wmode;
  assign addr_ok = {1'b0, RW0_addr} < DEPTH_L;

  // Init sweep / run control; ready is registered alongside the state.
  always_ff @(posedge RW0_clk) begin
    if (RW0_reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ADDR) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
            cnt_q   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Array storage: sweep writes full words, run writes honour the lane mask.
  // Out-of-range writes are simply dropped.
  always_ff @(posedge RW0_clk) begin
    if (!RW0_reset) begin
      if (state_q == ST_INIT) begin
        ram[cnt_q] <= INIT_VAL;
      end else if (req_ok && RW0_wmode && addr_ok) begin
        for (int l = 0; l < MW; l++) begin
          if (RW0_wmask[l]) ram[RW0_addr][l*GRAN +: GRAN] <= RW0_wdata[l*GRAN +: GRAN];
        end
      end
    end
  end

  // Captured read address. rhit_q is low after reset and for out-of-range
  // reads, which forces the returned data to zero.
  logic [ADDR_W-1:0] raddr_q;
  logic              rhit_q;
  logic              v1_q;

  always_ff @(posedge RW0_clk) begin
    if (RW0_reset) begin
      raddr_q <= '0;
      rhit_q  <= 1'b0;
      v1_q    <= 1'b0;
    end else begin
      v1_q <= rd_req;
      if (rd_req) begin
        raddr_q <= RW0_addr;
        rhit_q  <= addr_ok;
      end
    end
  end

  // Combinational array read: follows later writes to the captured address.
  logic [DATA_W-1:0] arr_data;
  assign arr_data = rhit_q ? ram[raddr_q] : '0;

  logic [DATA_W-1:0] true_data;
  logic              rvalid;

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] rdata_q;
      logic              rvalid_q;
      always_ff @(posedge RW0_clk) begin
        if (RW0_reset) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rvalid_q <= v1_q;
          if (v1_q) rdata_q <= arr_data;
        end
      end
      assign true_data = rdata_q;
      assign rvalid    = rvalid_q;
    end else begin : g_flow
      assign true_data = arr_data;
      assign rvalid    = v1_q;
    end
  endgenerate

`ifdef MASKED_SRAM_GARBAGE_EN
  logic [31:0]       lfsr;
  logic [DATA_W-1:0] garb;

  masked_sram_lfsr u_lfsr (
    .clk_i   (RW0_clk),
    .rst_i   (RW0_reset),
    .en_i    (state_q == ST_RUN),
    .state_o (lfsr)
  );

  always_comb begin
    garb = '0;
    for (int i = 0; i < DATA_W; i++) garb[i] = lfsr[5'(i % 32)];
  end

  assign RW0_rdata = rvalid ? true_data
                   : ((state_q == ST_RUN && !RW0_reset) ? garb : '0);
`else
  assign RW0_rdata = true_data;
`endif

  assign RW0_rvalid = rvalid;
  assign RW0_ready  = ready_q;

endmodule

// File: tb/tb_masked_sram_ext.sv
// tb/tb_masked_sram_ext.sv - self-checking bench for masked_sram_ext
module tb_masked_sram_ext;

  logic        clk = 1'b0;
  logic        rst_ab = 1'b1;
  logic        en = 1'b0, wmode = 1'b0;
  logic [3:0]  addr = '0;
  logic [7:0]  wmask = '0;
  logic [63:0] wdata = '0;
  logic [63:0] a_rdata, b_rdata;
  logic        a_rvalid, b_rvalid, a_ready, b_ready;

  logic        rst_c = 1'b1;
  logic        c_en = 1'b0, c_wmode = 1'b0;
  logic [3:0]  c_addr = '0;
  logic [7:0]  c_wmask = '0;
  logic [63:0] c_wdata = '0;
  logic [63:0] c_rdata;
  logic        c_rvalid, c_ready;

  always #5 clk = ~clk;

  masked_sram_ext #(.DATA_W(64), .DEPTH(16), .ADDR_W(4), .GRAN(8), .OUT_REG(0), .INIT_VAL(64'hA5)) u_a (
    .RW0_clk(clk), .RW0_reset(rst_ab), .RW0_addr(addr), .RW0_en(en), .RW0_wmode(wmode),
    .RW0_wmask(wmask), .RW0_wdata(wdata), .RW0_rdata(a_rdata), .RW0_rvalid(a_rvalid), .RW0_ready(a_ready));

  masked_sram_ext #(.DATA_W(64), .DEPTH(16), .ADDR_W(4), .GRAN(8), .OUT_REG(1), .INIT_VAL(64'hA5)) u_b (
    .RW0_clk(clk), .RW0_reset(rst_ab), .RW0_addr(addr), .RW0_en(en), .RW0_wmode(wmode),
    .RW0_wmask(wmask), .RW0_wdata(wdata), .RW0_rdata(b_rdata), .RW0_rvalid(b_rvalid), .RW0_ready(b_ready));

  masked_sram_ext #(.DATA_W(64), .DEPTH(12), .ADDR_W(4), .GRAN(8), .OUT_REG(0), .INIT_VAL(64'h0F0F)) u_c (
    .RW0_clk(clk), .RW0_reset(rst_c), .RW0_addr(c_addr), .RW0_en(c_en), .RW0_wmode(c_wmode),
    .RW0_wmask(c_wmask), .RW0_wdata(c_wdata), .RW0_rdata(c_rdata), .RW0_rvalid(c_rvalid), .RW0_ready(c_ready));

  int errors = 0;
  int checks = 0;

  // Reference model for the two 16-word arrays (they see identical traffic).
  logic [63:0] mem [16];
  bit          run;
  bit          a_has;
  logic [3:0]  a_addr;
  bit          p1_v;
  logic [63:0] p1_d;
  bit          exp_av, exp_bv;
  logic [63:0] exp_ad, exp_bd;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem[i] = 64'hA5;
    run = 0; a_has = 0; a_addr = '0; p1_v = 0; p1_d = '0;
    exp_av = 0; exp_bv = 0; exp_ad = '0; exp_bd = '0;
  endtask

  // One clock with the given request; afterwards the expectations hold the
  // values both arrays should show #1 after the edge.
  task automatic step(input bit e, input bit w, input logic [3:0] ad,
                      input logic [7:0] m, input logic [63:0] d);
    en = e; wmode = w; addr = ad; wmask = m; wdata = d;
    @(posedge clk); #1;
    exp_bv = p1_v;
    if (p1_v) exp_bd = p1_d;
    p1_v = 0;
    exp_av = 0;
    if (run && e) begin
      if (w) begin
        for (int l = 0; l < 8; l++) if (m[l]) mem[ad][l*8 +: 8] = d[l*8 +: 8];
      end else begin
        exp_av = 1; a_has = 1; a_addr = ad;
        p1_v = 1; p1_d = mem[ad];
      end
    end
    exp_ad = a_has ? mem[a_addr] : 64'h0;
    en = 1'b0;
  endtask

  task automatic test_reset();
    int  zeros;
    bit  seen_v;
    rst_ab = 1'b1;
    @(posedge clk); #1;
    checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin errors++; $display("FAIL reset_ready a=%b b=%b exp 0", a_ready, b_ready); end
    checks++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid a=%b b=%b exp 0", a_rvalid, b_rvalid); end
    checks++; if (a_rdata !== 64'h0 || b_rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata a=%h b=%h exp 0", a_rdata, b_rdata); end
    rst_ab = 1'b0;
    model_reset();
    zeros = 1; seen_v = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'($urandom), 4'($urandom), 8'hFF, {$urandom, $urandom});
      if (a_rvalid || b_rvalid) seen_v = 1;
      if (a_ready) break;
      zeros++;
    end
    checks++; if (zeros != 16) begin errors++; $display("FAIL init_ready_low_cycles got=%0d exp=16", zeros); end
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin errors++; $display("FAIL init_ready_rise a=%b b=%b exp 1", a_ready, b_ready); end
    checks++; if (seen_v) begin errors++; $display("FAIL init_no_rvalid got=1 exp=0"); end
    run = 1;
  endtask

  task automatic test_init_sweep();
    for (int a = 0; a < 17; a++) begin
      step(a < 16, 1'b0, 4'(a), 8'h00, 64'h0);
      if (a < 16) begin
        checks++; if (a_rvalid !== 1'b1 || a_rdata !== 64'hA5) begin errors++; $display("FAIL sweep_a addr=%0d got v=%b d=%h exp v=1 d=a5", a, a_rvalid, a_rdata); end
      end
      if (a > 0) begin
        checks++; if (b_rvalid !== 1'b1 || b_rdata !== 64'hA5) begin errors++; $display("FAIL sweep_b addr=%0d got v=%b d=%h exp v=1 d=a5", a - 1, b_rvalid, b_rdata); end
      end
    end
  endtask

  task automatic test_masked_write();
    step(1'b1, 1'b1, 4'd3, 8'hFF, 64'h1122334455667788);
    step(1'b1, 1'b1, 4'd3, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1'b1, 1'b0, 4'd3, 8'h00, 64'h0);
    checks++; if (a_rvalid !== 1'b1 || a_rdata !== 64'h11223344FFFFFFFF) begin errors++; $display("FAIL masked_a got v=%b d=%h exp v=1 d=11223344ffffffff", a_rvalid, a_rdata); end
    step(1'b0, 1'b0, 4'd0, 8'h00, 64'h0);
    checks++; if (b_rvalid !== 1'b1 || b_rdata !== 64'h11223344FFFFFFFF) begin errors++; $display("FAIL masked_b got v=%b d=%h exp v=1 d=11223344ffffffff", b_rvalid, b_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] v [3];
    logic [4:0]  a_pat, b_pat;
    for (int k = 0; k < 3; k++) begin
      v[k] = {$urandom, $urandom};
      step(1'b1, 1'b1, 4'(k), 8'hFF, v[k]);
    end
    a_pat = '0; b_pat = '0;
    for (int k = 0; k < 5; k++) begin
      step(k < 3, 1'b0, 4'(k), 8'h00, 64'h0);
      a_pat[k] = a_rvalid;
      b_pat[k] = b_rvalid;
      if (k < 3) begin
        checks++; if (a_rdata !== v[k]) begin errors++; $display("FAIL b2b_a_data idx=%0d got=%h exp=%h", k, a_rdata, v[k]); end
      end
      if (k >= 1 && k <= 3) begin
        checks++; if (b_rdata !== v[k-1]) begin errors++; $display("FAIL b2b_b_data idx=%0d got=%h exp=%h", k - 1, b_rdata, v[k-1]); end
      end
    end
    checks++; if (a_pat !== 5'b00111) begin errors++; $display("FAIL b2b_a_rvalid got=%b exp=00111", a_pat); end
    checks++; if (b_pat !== 5'b01110) begin errors++; $display("FAIL b2b_b_rvalid got=%b exp=01110", b_pat); end
  endtask

  task automatic test_flow_through();
    logic [63:0] x, y;
    x = {$urandom, $urandom};
    y = ~x;
    step(1'b1, 1'b1, 4'd5, 8'hFF, x);
    step(1'b1, 1'b0, 4'd5, 8'h00, 64'h0);
    step(1'b1, 1'b1, 4'd5, 8'hFF, y);
    step(1'b0, 1'b0, 4'd0, 8'h00, 64'h0);
    step(1'b0, 1'b0, 4'd0, 8'h00, 64'h0);
`ifndef MASKED_SRAM_GARBAGE_EN
    checks++; if (a_rdata !== y) begin errors++; $display("FAIL flow_a got=%h exp=%h", a_rdata, y); end
    checks++; if (b_rdata !== x) begin errors++; $display("FAIL hold_b got=%h exp=%h", b_rdata, x); end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step(($urandom % 4) != 0, 1'($urandom), 4'($urandom), 8'($urandom), {$urandom, $urandom});
      checks++; if (a_rvalid !== exp_av) begin errors++; $display("FAIL rand_a_rvalid cyc=%0d got=%b exp=%b", i, a_rvalid, exp_av); end
      checks++; if (b_rvalid !== exp_bv) begin errors++; $display("FAIL rand_b_rvalid cyc=%0d got=%b exp=%b", i, b_rvalid, exp_bv); end
`ifndef MASKED_SRAM_GARBAGE_EN
      checks++; if (a_rdata !== exp_ad) begin errors++; $display("FAIL rand_a_rdata cyc=%0d got=%h exp=%h", i, a_rdata, exp_ad); end
      checks++; if (b_rdata !== exp_bd) begin errors++; $display("FAIL rand_b_rdata cyc=%0d got=%h exp=%h", i, b_rdata, exp_bd); end
`else
      if (exp_av) begin
        checks++; if (a_rdata !== exp_ad) begin errors++; $display("FAIL rand_a_rdata cyc=%0d got=%h exp=%h", i, a_rdata, exp_ad); end
      end
      if (exp_bv) begin
        checks++; if (b_rdata !== exp_bd) begin errors++; $display("FAIL rand_b_rdata cyc=%0d got=%h exp=%h", i, b_rdata, exp_bd); end
      end
`endif
    end
  endtask

  task automatic test_reset_midsweep_oor();
    int n;
    c_en = 1'b0;
    rst_c = 1'b1;
    @(posedge clk); #1;
    rst_c = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_c = 1'b1;
    @(posedge clk); #1;
    checks++; if (c_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready got=%b exp=0", c_ready); end
    rst_c = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      n++;
      if (c_ready) break;
    end
    checks++; if (n != 12) begin errors++; $display("FAIL mid_reset_sweep_len got=%0d exp=12", n); end
    c_en = 1'b1; c_wmode = 1'b1; c_addr = 4'd13; c_wmask = 8'hFF; c_wdata = {$urandom, $urandom};
    @(posedge clk); #1;
    c_wmode = 1'b0;
    @(posedge clk); #1;
    checks++; if (c_rvalid !== 1'b1 || c_rdata !== 64'h0) begin errors++; $display("FAIL oor_read got v=%b d=%h exp v=1 d=0", c_rvalid, c_rdata); end
    c_addr = 4'd1;
    @(posedge clk); #1;
    checks++; if (c_rvalid !== 1'b1 || c_rdata !== 64'h0F0F) begin errors++; $display("FAIL oor_no_alias got v=%b d=%h exp v=1 d=0f0f", c_rvalid, c_rdata); end
    c_addr = 4'd11;
    @(posedge clk); #1;
    checks++; if (c_rvalid !== 1'b1 || c_rdata !== 64'h0F0F) begin errors++; $display("FAIL last_word got v=%b d=%h exp v=1 d=0f0f", c_rvalid, c_rdata); end
    c_en = 1'b0;
    @(posedge clk); #1;
    checks++; if (c_rvalid !== 1'b0) begin errors++; $display("FAIL idle_rvalid got=%b exp=0", c_rvalid); end
  endtask

`ifdef MASKED_SRAM_GARBAGE_EN
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
  endfunction

  task automatic test_garbage();
    logic [31:0] g;
    rst_ab = 1'b1;
    @(posedge clk); #1;
    rst_ab = 1'b0;
    model_reset();
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b0, 4'd0, 8'h00, 64'h0);
      if (a_ready) break;
    end
    g = 32'h1;
    checks++; if (a_rdata !== {g, g}) begin errors++; $display("FAIL garb_seed got=%h exp=%h", a_rdata, {g, g}); end
    run = 1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 4'd0, 8'h00, 64'h0);
      g = lfsr_next(g);
      checks++; if (a_rdata !== {g, g}) begin errors++; $display("FAIL garb_idle%0d got=%h exp=%h", i, a_rdata, {g, g}); end
    end
    step(1'b1, 1'b0, 4'd2, 8'h00, 64'h0);
    g = lfsr_next(g);
    checks++; if (a_rvalid !== 1'b1 || a_rdata !== 64'hA5) begin errors++; $display("FAIL garb_read got v=%b d=%h exp v=1 d=a5", a_rvalid, a_rdata); end
    step(1'b0, 1'b0, 4'd0, 8'h00, 64'h0);
    g = lfsr_next(g);
    checks++; if (a_rdata !== {g, g}) begin errors++; $display("FAIL garb_after got=%h exp=%h", a_rdata, {g, g}); end
  endtask
`endif

  initial begin
    test_reset();
    test_init_sweep();
    test_masked_write();
    test_back_to_back();
    test_flow_through();
    test_random();
    test_reset_midsweep_oor();
`ifdef MASKED_SRAM_GARBAGE_EN
    test_garbage();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
